rgu_rst_src_cond: RTL and testbench

Reset-source conditioner that sits directly upstream of the reset generation unit. It synchronises and debounces the board reset pad, and synchronises the always-on and per-cluster watchdog reset requests. It stretches every request to a guaranteed minimum width and drives the clean `sys_reset_n`, `sb_wdt_rst_n` and `wdt_rst_n[3:0]` consumed by the RGU. It also keeps a sticky reset-cause register for firmware.

---
 rtl/rgu_pkg.sv | 24 ++
 rtl/rgu_rst_stretch.sv | 37 +++
 rtl/rgu_rst_src_cond.sv | 199 +++++++++++++++++++
 tb/tb_rgu_rst_src_cond.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/rgu_pkg.sv
// Shared definitions for the reset-source conditioner.
//   dbnc_state_e : pad debounce FSM states
//   CAUSE_*      : bit positions inside rst_cause
//   DEF_*        : default parameter values
package rgu_pkg;

  typedef enum logic [1:0] {
    IDLE_HI = 2'd0,
    CHK_LO  = 2'd1,
    ASSERT  = 2'd2,
    CHK_HI  = 2'd3
  } dbnc_state_e;

  localparam int unsigned CAUSE_POR    = 0;
  localparam int unsigned CAUSE_PAD    = 1;
  localparam int unsigned CAUSE_SW     = 2;
  localparam int unsigned CAUSE_SB_WDT = 3;
  localparam int unsigned CAUSE_WDT0   = 4;

  localparam int unsigned DEF_SYNC_STAGES  = 2;
  localparam int unsigned DEF_DEBOUNCE_CYC = 1024;
  localparam int unsigned DEF_STRETCH_CYC  = 16;

endpackage

// File: rtl/rgu_rst_stretch.sv
// One stretch channel: turns an active-high request into an active-low
// registered reset that stays low for STRETCH_CYC cycles after the request ends.
//   clk        : clock
//   rst_n      : asynchronous active-low reset (counter loaded, output low)
//   req        : active-high reset request
//   cond_rst_n : registered, stretched active-low reset
module rgu_rst_stretch #(
  parameter int unsigned STRETCH_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  output logic cond_rst_n
);

  localparam int unsigned      CNT_W    = $clog2(STRETCH_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STRETCH_CYC);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= CNT_LOAD;
      cond_rst_n <= 1'b0;
    end else begin
      if (req) begin
        cnt_q <= CNT_LOAD;
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      // Uses the pre-decrement count, so a one-cycle request gives
      // STRETCH_CYC+1 low cycles.
      cond_rst_n <= ~(req | (cnt_q != '0));
    end
  end

endmodule

// File: rtl/rgu_rst_src_cond.sv
// Reset-source conditioner in front of the RGU. Synchronises the pad and
// watchdog requests, debounces the pad, stretches every request and keeps a
// sticky reset-cause register.
// Optional feature macro: RGU_SRC_SW_RST_EN (adds sw_rst_req into the sys
// channel and rst_cause[2]).
// Ports:
//   clk             : always-on clock
//   sys_pwrgd       : async active-low reset of this block
//   pad_reset_n     : raw board reset pad (async, bouncy, active-low)
//   sb_wdt_req_n    : always-on watchdog request (async, active-low)
//   wdt_req_n[3:0]  : cluster watchdog requests (async, active-low)
//   sw_rst_req      : one-cycle software reset request (macro only)
//   cause_clr       : one-cycle clear of rst_cause
//   i_test_mode     : DFT mode select
//   i_dft_test_rstn : DFT reset driven onto all outputs in test mode
//   sys_reset_n     : conditioned system reset
//   sb_wdt_rst_n    : conditioned always-on watchdog reset
//   wdt_rst_n[3:0]  : conditioned cluster watchdog resets
//   rst_cause[7:0]  : sticky cause {wdt[3:0], sb_wdt, sw, pad, por}
module rgu_rst_src_cond
  import rgu_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int unsigned STRETCH_CYC  = DEF_STRETCH_CYC
) (
  input  logic       clk,
  input  logic       sys_pwrgd,
  input  logic       pad_reset_n,
  input  logic       sb_wdt_req_n,
  input  logic [3:0] wdt_req_n,
`ifdef RGU_SRC_SW_RST_EN
  input  logic       sw_rst_req,
`endif
  input  logic       cause_clr,
  input  logic       i_test_mode,
  input  logic       i_dft_test_rstn,
  output logic       sys_reset_n,
  output logic       sb_wdt_rst_n,
  output logic [3:0] wdt_rst_n,
  output logic [7:0] rst_cause
);

  localparam int unsigned NSYNC = 6;
  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYC);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
  // Requests are active while in reset, so their edge history starts active
  // and leaving reset does not log spurious causes. Bit 2 (sw) starts idle.
  localparam logic [7:0] REQ_PREV_RST = 8'hFB;

  // ---------------- synchronisers ----------------
  logic [NSYNC-1:0]                   async_in;
  logic [SYNC_STAGES-1:0][NSYNC-1:0]  sync_q;
  logic                               pad_s;
  logic                               sb_s;
  logic [3:0]                         wdt_s;

  assign async_in = {wdt_req_n, sb_wdt_req_n, pad_reset_n};

  always_ff @(posedge clk or negedge sys_pwrgd) begin
    if (!sys_pwrgd) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
    end
  end

  assign pad_s = sync_q[SYNC_STAGES-1][0];
  assign sb_s  = sync_q[SYNC_STAGES-1][1];
  assign wdt_s = sync_q[SYNC_STAGES-1][5:2];

  // ---------------- pad debounce FSM ----------------
  dbnc_state_e     state_q, state_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            pad_req;

  always_ff @(posedge clk or negedge sys_pwrgd) begin
    if (!sys_pwrgd) begin
      state_q  <= ASSERT;
      db_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    case (state_q)
      IDLE_HI: begin
        if (!pad_s) begin
          state_d  = CHK_LO;
          db_cnt_d = '0;
        end
      end
      CHK_LO: begin
        if (pad_s) begin
          state_d = IDLE_HI;
        end else if (db_cnt_q == DB_LAST) begin
          state_d = ASSERT;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      ASSERT: begin
        if (pad_s) begin
          state_d  = CHK_HI;
          db_cnt_d = '0;
        end
      end
      CHK_HI: begin
        if (!pad_s) begin
          state_d = ASSERT;
        end else if (db_cnt_q == DB_LAST) begin
          state_d = IDLE_HI;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      default: state_d = ASSERT;
    endcase
  end

  assign pad_req = (state_q == ASSERT) || (state_q == CHK_HI);

  // ---------------- system request ----------------
  logic sw_req;
`ifdef RGU_SRC_SW_RST_EN
  assign sw_req = sw_rst_req;
`else
  assign sw_req = 1'b0;
`endif

  logic sys_req;
  assign sys_req = pad_req | sw_req;

  // ---------------- stretch channels ----------------
  logic       sys_q;
  logic       sb_q;
  logic [3:0] wdt_q;

  rgu_rst_stretch #(.STRETCH_CYC(STRETCH_CYC)) u_sys (
    .clk        (clk),
    .rst_n      (sys_pwrgd),
    .req        (sys_req),
    .cond_rst_n (sys_q)
  );

  rgu_rst_stretch #(.STRETCH_CYC(STRETCH_CYC)) u_sb (
    .clk        (clk),
    .rst_n      (sys_pwrgd),
    .req        (~sb_s),
    .cond_rst_n (sb_q)
  );

  for (genvar g = 0; g < 4; g++) begin : g_wdt
    rgu_rst_stretch #(.STRETCH_CYC(STRETCH_CYC)) u_wdt (
      .clk        (clk),
      .rst_n      (sys_pwrgd),
      .req        (~wdt_s[g]),
      .cond_rst_n (wdt_q[g])
    );
  end

  // ---------------- cause capture ----------------
  logic [7:0] req_vec;
  logic [7:0] req_prev_q;
  logic [7:0] cause_q;
  logic [7:0] cause_d;

  always_comb begin
    req_vec                 = '0;
    req_vec[CAUSE_PAD]      = pad_req;
    req_vec[CAUSE_SW]       = sw_req;
    req_vec[CAUSE_SB_WDT]   = ~sb_s;
    req_vec[CAUSE_WDT0+:4]  = ~wdt_s;
  end

  // Clear first, then OR in new edges so a set wins over a same-cycle clear.
  assign cause_d = (cause_clr ? 8'h00 : cause_q) | (req_vec & ~req_prev_q);

  always_ff @(posedge clk or negedge sys_pwrgd) begin
    if (!sys_pwrgd) begin
      req_prev_q <= REQ_PREV_RST;
      cause_q    <= 8'h01;
    end else begin
      req_prev_q <= req_vec;
      cause_q    <= cause_d;
    end
  end

  // ---------------- outputs / test-mode mux ----------------
  assign sys_reset_n  = i_test_mode ? i_dft_test_rstn : sys_q;
  assign sb_wdt_rst_n = i_test_mode ? i_dft_test_rstn : sb_q;
  assign wdt_rst_n    = i_test_mode ? {4{i_dft_test_rstn}} : wdt_q;
  assign rst_cause    = cause_q;

endmodule

// File: tb/tb_rgu_rst_src_cond.sv
// Self-checking bench for rgu_rst_src_cond with SYNC_STAGES=2,
// DEBOUNCE_CYC=8, STRETCH_CYC=4. Inputs change 1 time unit after a rising
// edge; outputs are sampled 1 time unit after the edge of interest.
module tb_rgu_rst_src_cond;

  logic       clk;
  logic       sys_pwrgd;
  logic       pad_reset_n;
  logic       sb_wdt_req_n;
  logic [3:0] wdt_req_n;
`ifdef RGU_SRC_SW_RST_EN
  logic       sw_rst_req;
`endif
  logic       cause_clr;
  logic       i_test_mode;
  logic       i_dft_test_rstn;
  logic       sys_reset_n;
  logic       sb_wdt_rst_n;
  logic [3:0] wdt_rst_n;
  logic [7:0] rst_cause;

  int unsigned n_chk;
  int unsigned n_fail;

  rgu_rst_src_cond #(
    .SYNC_STAGES  (2),
    .DEBOUNCE_CYC (8),
    .STRETCH_CYC  (4)
  ) dut (
    .clk             (clk),
    .sys_pwrgd       (sys_pwrgd),
    .pad_reset_n     (pad_reset_n),
    .sb_wdt_req_n    (sb_wdt_req_n),
    .wdt_req_n       (wdt_req_n),
`ifdef RGU_SRC_SW_RST_EN
    .sw_rst_req      (sw_rst_req),
`endif
    .cause_clr       (cause_clr),
    .i_test_mode     (i_test_mode),
    .i_dft_test_rstn (i_dft_test_rstn),
    .sys_reset_n     (sys_reset_n),
    .sb_wdt_rst_n    (sb_wdt_rst_n),
    .wdt_rst_n       (wdt_rst_n),
    .rst_cause       (rst_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  wdt_n;
    logic        tm;
    logic        dft;
    int unsigned adv;
    logic        exp_sys;
    logic        exp_sb;
    logic [3:0]  exp_wdt;
    logic [7:0]  exp_cause;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string name, logic [3:0] wdt_n, logic tm,
                              logic dft, int unsigned adv, logic exp_sys,
                              logic exp_sb, logic [3:0] exp_wdt,
                              logic [7:0] exp_cause);
    vec_t v;
    v.name      = name;
    v.wdt_n     = wdt_n;
    v.tm        = tm;
    v.dft       = dft;
    v.adv       = adv;
    v.exp_sys   = exp_sys;
    v.exp_sb    = exp_sb;
    v.exp_wdt   = exp_wdt;
    v.exp_cause = exp_cause;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic seen_low;

  initial begin
    n_chk           = 0;
    n_fail          = 0;
    sys_pwrgd       = 1'b1;
    pad_reset_n     = 1'b1;
    sb_wdt_req_n    = 1'b1;
    wdt_req_n       = 4'hF;
`ifdef RGU_SRC_SW_RST_EN
    sw_rst_req      = 1'b0;
`endif
    cause_clr       = 1'b0;
    i_test_mode     = 1'b0;
    i_dft_test_rstn = 1'b1;

    // wdt one-cycle pulse on cluster 1, then test-mode overrides
    tbl.push_back(mk("wdt_e0",     4'b1101, 0, 1, 1, 1, 1, 4'b1111, 8'h03));
    tbl.push_back(mk("wdt_e1",     4'b1111, 0, 1, 1, 1, 1, 4'b1111, 8'h03));
    tbl.push_back(mk("wdt_e2_low", 4'b1111, 0, 1, 1, 1, 1, 4'b1101, 8'h23));
    tbl.push_back(mk("wdt_e6_low", 4'b1111, 0, 1, 4, 1, 1, 4'b1101, 8'h23));
    tbl.push_back(mk("wdt_e7_rel", 4'b1111, 0, 1, 1, 1, 1, 4'b1111, 8'h23));
    tbl.push_back(mk("tm_dft0",    4'b1111, 1, 0, 0, 0, 0, 4'b0000, 8'h23));
    tbl.push_back(mk("tm_dft1",    4'b1111, 1, 1, 0, 1, 1, 4'b1111, 8'h23));
    tbl.push_back(mk("tm_dft0_run",4'b1111, 1, 0, 3, 0, 0, 4'b0000, 8'h23));
    tbl.push_back(mk("tm_exit",    4'b1111, 0, 0, 0, 1, 1, 4'b1111, 8'h23));

    // ---- power-on reset ----
    #2 sys_pwrgd = 1'b0;
    step(3);
    chk("por_sys", sys_reset_n, 1'b0);
    chk("por_sb", sb_wdt_rst_n, 1'b0);
    chk("por_wdt", wdt_rst_n, 4'h0);
    chk("por_cause", rst_cause, 8'h01);
    sys_pwrgd = 1'b1;
    step(6);
    chk("por_wdt_e5", wdt_rst_n, 4'h0);
    chk("por_sb_e5", sb_wdt_rst_n, 1'b0);
    step(1);
    chk("por_wdt_e6", wdt_rst_n, 4'hF);
    chk("por_sb_e6", sb_wdt_rst_n, 1'b1);
    step(8);
    chk("por_sys_e14", sys_reset_n, 1'b0);
    step(1);
    chk("por_sys_e15", sys_reset_n, 1'b1);
    chk("por_cause_after", rst_cause, 8'h01);

    // ---- pad glitch shorter than debounce ----
    seen_low    = 1'b0;
    pad_reset_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (sys_reset_n !== 1'b1) seen_low = 1'b1;
    end
    pad_reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (sys_reset_n !== 1'b1) seen_low = 1'b1;
    end
    chk("glitch_sys_low_seen", seen_low, 1'b0);
    chk("glitch_cause_pad", rst_cause[1], 1'b0);

    // ---- pad held low 20 cycles ----
    pad_reset_n = 1'b0;
    step(11);
    chk("pad_e10_high", sys_reset_n, 1'b1);
    step(1);
    chk("pad_e11_low", sys_reset_n, 1'b0);
    step(8);
    chk("pad_cause", rst_cause, 8'h03);
    pad_reset_n = 1'b1;
    step(15);
    chk("pad_rel_e14_low", sys_reset_n, 1'b0);
    step(1);
    chk("pad_rel_e15_high", sys_reset_n, 1'b1);

    // ---- table-driven wdt pulse and test mode ----
    foreach (tbl[i]) begin
      wdt_req_n       = tbl[i].wdt_n;
      i_test_mode     = tbl[i].tm;
      i_dft_test_rstn = tbl[i].dft;
      if (tbl[i].adv == 0) #1;
      else step(tbl[i].adv);
      chk({tbl[i].name, "_sys"},   sys_reset_n,  tbl[i].exp_sys);
      chk({tbl[i].name, "_sb"},    sb_wdt_rst_n, tbl[i].exp_sb);
      chk({tbl[i].name, "_wdt"},   wdt_rst_n,    tbl[i].exp_wdt);
      chk({tbl[i].name, "_cause"}, rst_cause,    tbl[i].exp_cause);
    end
    i_dft_test_rstn = 1'b1;

    // ---- cause_clr coincident with sb_wdt synced edge ----
    sb_wdt_req_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 cause_clr = 1'b1;
    step(1);
    cause_clr = 1'b0;
    chk("clr_vs_sb_set", rst_cause, 8'h08);
    sb_wdt_req_n = 1'b1;
    step(12);
    chk("sb_released", sb_wdt_rst_n, 1'b1);

    // ---- sys_pwrgd drop in the middle of a stretch ----
    wdt_req_n = 4'b1110;
    step(1);
    wdt_req_n = 4'b1111;
    step(3);
    chk("mid_wdt0_low", wdt_rst_n, 4'b1110);
    #3 sys_pwrgd = 1'b0;
    #1;
    chk("mid_sys", sys_reset_n, 1'b0);
    chk("mid_sb", sb_wdt_rst_n, 1'b0);
    chk("mid_wdt", wdt_rst_n, 4'h0);
    chk("mid_cause", rst_cause, 8'h01);
    step(2);
    sys_pwrgd = 1'b1;
    step(16);
    chk("mid_recover_sys", sys_reset_n, 1'b1);
    chk("mid_recover_wdt", wdt_rst_n, 4'hF);

`ifdef RGU_SRC_SW_RST_EN
    // ---- software reset pulse ----
    sw_rst_req = 1'b1;
    step(1);
    sw_rst_req = 1'b0;
    chk("sw_e0_low", sys_reset_n, 1'b0);
    chk("sw_cause", rst_cause, 8'h05);
    step(4);
    chk("sw_e4_low", sys_reset_n, 1'b0);
    step(1);
    chk("sw_e5_high", sys_reset_n, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
